// File: rtl/bp_pkg.sv
// Shared types and counter rules for the branch predictor PHT.
// Counter encoding: SN=00, WN=01, WT=10, ST=11.
package bp_pkg;

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } pht_counter_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    function automatic pht_counter_t next_counter(
        input pht_counter_t c,
        input logic         taken
    );
        pht_counter_t n;
        unique case (c)
            SN: n = taken ? WN : SN;
            WN: n = taken ? WT : SN;
            WT: n = taken ? ST : WN;
            ST: n = taken ? ST : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pht_update_queue.sv
// FIFO of pending PHT writes with a parallel index lookup.
// The lookup reports the youngest matching entry.
module pht_update_queue
    import bp_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [IDX_W-1:0]   i_push_idx,
    input  pht_counter_t       i_push_ctr,
    input  logic               i_pop,
    output logic [IDX_W-1:0]   o_head_idx,
    output pht_counter_t       o_head_ctr,
    output logic               o_empty,
    output logic               o_full,
    input  logic [IDX_W-1:0]   i_match_idx,
    output logic               o_hit,
    output pht_counter_t       o_hit_ctr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [IDX_W-1:0] r_idx [DEPTH];
    pht_counter_t     r_ctr [DEPTH];
    logic [PW-1:0]    w_count;

    assign w_count    = r_wr - r_rd;
    assign o_empty    = (r_wr == r_rd);
    assign o_full     = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
    assign o_head_idx = r_idx[r_rd[AW-1:0]];
    assign o_head_ctr = r_ctr[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_idx[r_wr[AW-1:0]] <= i_push_idx;
            r_ctr[r_wr[AW-1:0]] <= i_push_ctr;
        end
    end

    // Walk oldest to youngest so the last match found wins.
    always_comb begin
        logic [AW-1:0] w_slot;
        w_slot    = '0;
        o_hit     = 1'b0;
        o_hit_ctr = SN;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = r_rd[AW-1:0] + AW'(k);
            if ((PW'(k) < w_count) && (r_idx[w_slot] == i_match_idx)) begin
                o_hit     = 1'b1;
                o_hit_ctr = r_ctr[w_slot];
            end
        end
    end

endmodule

// File: rtl/pht_access_controller.sv
// PHT owner: init sweep, update queue and single-port arbitration
// between IF lookups and MEM counter updates.
module pht_access_controller
    import bp_pkg::*;
#(
    parameter int         INDEX_BITS = 8,
    parameter int         UPD_DEPTH  = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [INDEX_BITS-1:0] lookup_index,
    output logic                  lookup_ready,
    output logic                  pred_valid,
    output logic [1:0]            pred_counter,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic [1:0]            upd_counter,
    input  logic                  upd_taken,
    output logic                  upd_ready,
    output logic                  init_done
);

    localparam int DEPTH = 1 << INDEX_BITS;

    ctrl_state_t           r_state;
    ctrl_state_t           w_state_nxt;
    logic [INDEX_BITS-1:0] r_ptr;
    logic [1:0]            r_ram [DEPTH];
    logic                  r_pred_valid;
    logic [1:0]            r_pred_counter;

    logic                  w_we;
    logic [INDEX_BITS-1:0] w_waddr;
    logic [1:0]            w_wdata;
    logic                  w_rd;
    logic                  w_pop;
    logic                  w_push;
    pht_counter_t          w_push_ctr;
    logic [INDEX_BITS-1:0] w_head_idx;
    pht_counter_t          w_head_ctr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_hit;
    pht_counter_t          w_hit_ctr;

    assign w_push_ctr = next_counter(pht_counter_t'(upd_counter), upd_taken);
    assign w_push     = upd_valid && upd_ready;

    pht_update_queue #(
        .IDX_W (INDEX_BITS),
        .DEPTH (UPD_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_idx  (upd_index),
        .i_push_ctr  (w_push_ctr),
        .i_pop       (w_pop),
        .o_head_idx  (w_head_idx),
        .o_head_ctr  (w_head_ctr),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .i_match_idx (lookup_index),
        .o_hit       (w_hit),
        .o_hit_ctr   (w_hit_ctr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) r_ptr <= r_ptr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_ptr == '1) w_state_nxt = RUN;
    end

    // A full queue preempts lookups so MEM never stalls indefinitely.
    always_comb begin
        w_we         = 1'b0;
        w_waddr      = w_head_idx;
        w_wdata      = w_head_ctr;
        w_rd         = 1'b0;
        w_pop        = 1'b0;
        lookup_ready = 1'b0;
        upd_ready    = 1'b0;
        unique case (r_state)
            INIT: begin
                w_we    = 1'b1;
                w_waddr = r_ptr;
                w_wdata = INIT_STATE;
            end
            RUN: begin
                upd_ready = !w_full;
                if (w_full) begin
                    w_we  = 1'b1;
                    w_pop = 1'b1;
                end else begin
                    lookup_ready = 1'b1;
                    if (lookup_valid) begin
                        w_rd = 1'b1;
                    end else if (!w_empty) begin
                        w_we  = 1'b1;
                        w_pop = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) r_ram[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid   <= 1'b0;
            r_pred_counter <= INIT_STATE;
        end else begin
            r_pred_valid <= w_rd;
            if (w_rd) r_pred_counter <= w_hit ? w_hit_ctr : r_ram[lookup_index];
        end
    end

    assign pred_valid   = r_pred_valid;
    assign pred_counter = r_pred_counter;
    assign init_done    = (r_state == RUN);

endmodule

// File: tb/tb_pht_access_controller.sv
// Scoreboard bench for pht_access_controller (INDEX_BITS=4, UPD_DEPTH=4).
// Reference: a flat table updated at enqueue time with saturating arithmetic.
module tb_pht_access_controller;

    localparam int IB = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_valid;
    logic [IB-1:0] lookup_index;
    logic          lookup_ready;
    logic          pred_valid;
    logic [1:0]    pred_counter;
    logic          upd_valid;
    logic [IB-1:0] upd_index;
    logic [1:0]    upd_counter;
    logic          upd_taken;
    logic          upd_ready;
    logic          init_done;

    int n_cmp = 0;
    int n_err = 0;
    int sb_q[$];
    int model[N];
    logic last_lr;
    logic last_ur;

    pht_access_controller #(
        .INDEX_BITS (IB),
        .UPD_DEPTH  (4),
        .INIT_STATE (2'b01)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .lookup_ready (lookup_ready),
        .pred_valid   (pred_valid),
        .pred_counter (pred_counter),
        .upd_valid    (upd_valid),
        .upd_index    (upd_index),
        .upd_counter  (upd_counter),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int ref_next(input int c, input bit t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    // One cycle of stimulus; expectations follow what the DUT accepts.
    task automatic step(input bit lv, input int li, input bit uv,
                        input int ui, input int uc, input bit ut);
        @(negedge clk);
        lookup_valid = lv;
        lookup_index = IB'(li);
        upd_valid    = uv;
        upd_index    = IB'(ui);
        upd_counter  = 2'(uc);
        upd_taken    = ut;
        #1;
        last_lr = lookup_ready;
        last_ur = upd_ready;
        if (lv && lookup_ready) sb_q.push_back(model[li]);
        if (uv && upd_ready) model[ui] = ref_next(uc, ut);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        lookup_valid = 1'b0;
        upd_valid    = 1'b0;
        @(posedge clk);
        for (int i = 0; i < N; i++) model[i] = 1;
        sb_q.delete();
        @(negedge clk);
        #1;
        chk("rst_lookup_ready", lookup_ready, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_counter", pred_counter, 1);
        chk("rst_init_done", init_done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            #1;
            chk("sweep_init_done", init_done, 0);
            chk("sweep_lookup_ready", lookup_ready, 0);
            @(negedge clk);
        end
        #1;
        chk("sweep_end_init_done", init_done, 1);
        chk("sweep_end_lookup_ready", lookup_ready, 1);
    endtask

    always @(negedge clk) begin
        int e;
        if (pred_valid === 1'b1 || sb_q.size() != 0) begin
            if (sb_q.size() == 0) begin
                chk("pred_unexpected", pred_valid, 0);
            end else begin
                e = sb_q.pop_front();
                chk("pred_valid", pred_valid, 1);
                chk("pred_counter", pred_counter, e);
            end
        end
    end

    initial begin
        int zeros;
        rst          = 1'b1;
        lookup_valid = 1'b0;
        lookup_index = '0;
        upd_valid    = 1'b0;
        upd_index    = '0;
        upd_counter  = '0;
        upd_taken    = 1'b0;
        do_reset();

        step(1, 5, 0, 0, 0, 0);
        idle(1);

        step(0, 0, 1, 3, 1, 1);
        idle(3);
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 1, 3, 3, 1);
        idle(3);
        step(1, 3, 0, 0, 0, 0);
        idle(1);

        step(1, 7, 0, 0, 0, 0);
        step(1, 7, 1, 7, 0, 1);
        step(1, 7, 1, 7, 2, 1);
        step(1, 7, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0);
        idle(4);

        for (int k = 0; k < 4; k++) begin
            step(1, $urandom_range(8, 11), 1, 8 + k, $urandom_range(0, 3), 1'($urandom));
            chk("fill_upd_ready", last_ur, 1);
        end
        zeros = 0;
        for (int j = 0; j < 8; j++) begin
            step(1, $urandom_range(8, 11), 0, 0, 0, 0);
            if (j == 0) chk("full_upd_ready", last_ur, 0);
            if (j == 0) chk("full_lookup_ready", last_lr, 0);
            if (j == 1) chk("after_full_upd_ready", last_ur, 1);
            if (!last_lr) zeros++;
        end
        chk("full_stall_cycles", zeros, 1);
        idle(5);

        for (int k = 0; k < 3; k++)
            step(1, 0, 1, 1 + k, $urandom_range(0, 3), 1'($urandom));
        do_reset();
        for (int i = 0; i < N; i++) step(1, i, 0, 0, 0, 0);
        idle(2);

        for (int c = 0; c < 4; c++)
            for (int t = 0; t < 2; t++)
                step(0, 0, 1, c * 2 + t, c, 1'(t));
        idle(5);
        for (int i = 0; i < 8; i++) step(1, i, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 1'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom));
        idle(8);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
